// File: rtl/ftq_pkg.sv
// Shared types and constants for the FTQ update scheduler and its resolution FIFO.
package ftq_pkg;

   typedef struct packed {
      int unsigned VLEN;
      int unsigned LOG2_INSTR_PER_FETCH;
   } cfg_t;

   localparam cfg_t cva6_cfg_empty = '{VLEN: 32'd32, LOG2_INSTR_PER_FETCH: 32'd2};

   // Width of an FTQ entry's prediction count (bp_count) and of the remaining counter.
   localparam int unsigned BP_COUNT_W = cva6_cfg_empty.LOG2_INSTR_PER_FETCH + 32'd1;

   typedef struct packed {
      logic [cva6_cfg_empty.VLEN-1:0] pc;
      logic                           taken;
      logic                           mispredict;
   } res_entry_t;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      ACTIVE = 2'b01,
      FLUSH  = 2'b10
   } sched_state_e;

endpackage

// File: rtl/ftq_res_fifo.sv
// In-order resolution FIFO: up to NR_PUSH writes per cycle (lower port is older),
// one read per cycle, synchronous clear and free-slot count from registered state.
module ftq_res_fifo
   import ftq_pkg::*;
#(
   parameter type         entry_t = res_entry_t,
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned NR_PUSH = 2
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       clr_i,
   input  logic [NR_PUSH-1:0]         push_i,
   input  entry_t                     data_i [NR_PUSH],
   input  logic                       pop_i,
   output entry_t                     head_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH+1)-1:0] free_o
);
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   entry_t           r_mem [DEPTH];
   logic [PTR_W-1:0] r_wptr;
   logic [PTR_W-1:0] r_rptr;
   logic [CNT_W-1:0] r_cnt;

   logic [PTR_W-1:0] w_wr_idx [NR_PUSH];
   logic [CNT_W-1:0] w_push_cnt;
   logic             w_pop;

   // Each accepted push lands after all older pushes of the same cycle.
   always_comb begin
      w_push_cnt = '0;
      for (int i = 0; i < NR_PUSH; i++) begin
         w_wr_idx[i] = r_wptr + w_push_cnt[PTR_W-1:0];
         w_push_cnt  = w_push_cnt + {{(CNT_W-1){1'b0}}, push_i[i]};
      end
      w_pop = pop_i && (r_cnt != '0);
   end

   // Entry storage.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else begin
         for (int i = 0; i < NR_PUSH; i++) begin
            if (push_i[i] && !clr_i) r_mem[w_wr_idx[i]] <= data_i[i];
         end
      end
   end

   // Pointers and occupancy; clear wins over same-cycle push/pop.
   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_cnt  <= '0;
      end else begin
         r_wptr <= r_wptr + w_push_cnt[PTR_W-1:0];
         r_rptr <= r_rptr + {{(PTR_W-1){1'b0}}, w_pop};
         r_cnt  <= r_cnt + w_push_cnt - {{(CNT_W-1){1'b0}}, w_pop};
      end
   end

   assign head_o  = r_mem[r_rptr];
   assign empty_o = (r_cnt == '0);
   assign free_o  = CNT_W'(DEPTH) - r_cnt;

endmodule

// File: rtl/ftq_update_sched.sv
// Sequences resolved branches into the predictor update port, pops the FTQ head once
// all its predictions are resolved, and flushes the FTQ after a mispredict update.
module ftq_update_sched
   import ftq_pkg::*;
#(
   parameter cfg_t        CVA6Cfg      = cva6_cfg_empty,
   parameter int unsigned NR_RES_PORTS = 2,
   parameter int unsigned UPD_DEPTH    = 4
) (
   input  logic                                       clk_i,
   input  logic                                       rst_i,
   input  logic                                       flush_i,
   input  logic                                       debug_mode_i,
   input  logic [NR_RES_PORTS-1:0]                    res_valid_i,
   output logic [NR_RES_PORTS-1:0]                    res_ready_o,
   input  logic [NR_RES_PORTS*CVA6Cfg.VLEN-1:0]       res_pc_i,
   input  logic [NR_RES_PORTS-1:0]                    res_taken_i,
   input  logic [NR_RES_PORTS-1:0]                    res_mispredict_i,
   input  logic                                       ftq_empty_i,
   input  logic [CVA6Cfg.LOG2_INSTR_PER_FETCH:0]      ftq_head_count_i,
   output logic                                       ftq_pop_o,
   output logic                                       ftq_flush_o,
   output logic                                       upd_valid_o,
   input  logic                                       upd_ready_i,
   output logic [CVA6Cfg.VLEN-1:0]                    upd_pc_o,
   output logic                                       upd_taken_o,
   output logic                                       upd_mispredict_o,
   output logic                                       busy_o
);
   localparam int unsigned VLEN   = CVA6Cfg.VLEN;
   localparam int unsigned CNT_W  = CVA6Cfg.LOG2_INSTR_PER_FETCH + 32'd1;
   localparam int unsigned FREE_W = $clog2(UPD_DEPTH + 32'd1);

   typedef struct packed {
      logic [VLEN-1:0] pc;
      logic            taken;
      logic            mispredict;
   } entry_t;

   sched_state_e      r_state;
   sched_state_e      w_state_nxt;
   logic [CNT_W-1:0]  r_rem;
   logic [CNT_W-1:0]  w_rem_nxt;
   logic [CNT_W-1:0]  w_rem_dec;

   entry_t              w_res [NR_RES_PORTS];
   entry_t              w_head;
   logic [NR_RES_PORTS-1:0] w_ready;
   logic [NR_RES_PORTS-1:0] w_push;
   logic [FREE_W-1:0]   w_free;
   logic                w_empty;
   logic                w_upd_valid;
   logic                w_hs;
   logic                w_fifo_pop;
   logic                w_fifo_clr;
   logic                w_ftq_pop;
   logic                w_ftq_flush;

   // Port accept and packing; ready looks only at registered occupancy, state and flush.
   always_comb begin
      for (int i = 0; i < NR_RES_PORTS; i++) begin
         w_ready[i] = (w_free >= FREE_W'(i + 1)) && (r_state != FLUSH) && !flush_i;
         w_push[i]  = res_valid_i[i] && w_ready[i];
         w_res[i]   = '{pc: res_pc_i[i*VLEN +: VLEN], taken: res_taken_i[i],
                        mispredict: res_mispredict_i[i]};
      end
   end

   ftq_res_fifo #(
      .entry_t (entry_t),
      .DEPTH   (UPD_DEPTH),
      .NR_PUSH (NR_RES_PORTS)
   ) u_res_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clr_i   (w_fifo_clr),
      .push_i  (w_push),
      .data_i  (w_res),
      .pop_i   (w_fifo_pop),
      .head_o  (w_head),
      .empty_o (w_empty),
      .free_o  (w_free)
   );

   // Next-state, remaining-prediction counter and FTQ/update strobes.
   always_comb begin
      w_state_nxt = r_state;
      w_rem_nxt   = r_rem;
      w_upd_valid = 1'b0;
      w_hs        = 1'b0;
      w_fifo_pop  = 1'b0;
      w_fifo_clr  = 1'b0;
      w_ftq_pop   = 1'b0;
      w_ftq_flush = 1'b0;
      w_rem_dec   = (r_rem != '0) ? (r_rem - CNT_W'(1)) : r_rem;
      case (r_state)
         IDLE: begin
            if (!ftq_empty_i) begin
               if (ftq_head_count_i == '0) begin
                  w_ftq_pop = 1'b1;
               end else begin
                  w_rem_nxt   = ftq_head_count_i;
                  w_state_nxt = ACTIVE;
               end
            end else begin
               w_state_nxt = IDLE;
            end
         end
         ACTIVE: begin
            w_upd_valid = !w_empty && !debug_mode_i;
            w_hs        = w_upd_valid && upd_ready_i;
            if (w_hs) begin
               w_fifo_pop = 1'b1;
               w_rem_nxt  = w_rem_dec;
               // A mispredict retires the entry through FLUSH, which also drops younger work.
               if (w_head.mispredict) begin
                  w_fifo_clr  = 1'b1;
                  w_rem_nxt   = '0;
                  w_state_nxt = FLUSH;
               end else if (w_rem_dec == '0) begin
                  w_ftq_pop   = 1'b1;
                  w_state_nxt = IDLE;
               end else begin
                  w_state_nxt = ACTIVE;
               end
            end else begin
               w_state_nxt = ACTIVE;
            end
         end
         FLUSH: begin
            w_ftq_flush = 1'b1;
            w_fifo_clr  = 1'b1;
            w_rem_nxt   = '0;
            w_state_nxt = IDLE;
         end
         default: begin
            w_fifo_clr  = 1'b1;
            w_rem_nxt   = '0;
            w_state_nxt = IDLE;
         end
      endcase
      // The external flush owns the FTQ, so only local state is dropped here.
      if (flush_i) begin
         w_fifo_clr  = 1'b1;
         w_rem_nxt   = '0;
         w_ftq_pop   = 1'b0;
         w_state_nxt = IDLE;
      end else begin
         w_fifo_clr  = w_fifo_clr;
      end
   end

   // State and counter registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= IDLE;
         r_rem   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_rem   <= w_rem_nxt;
      end
   end

   assign res_ready_o      = w_ready;
   assign ftq_pop_o        = w_ftq_pop;
   assign ftq_flush_o      = w_ftq_flush;
   assign upd_valid_o      = w_upd_valid;
   assign upd_pc_o         = w_head.pc;
   assign upd_taken_o      = w_head.taken;
   assign upd_mispredict_o = w_head.mispredict;
   assign busy_o           = !w_empty || (r_state != IDLE);

endmodule

// File: tb/tb_ftq_update_sched.sv
// Self-checking bench for ftq_update_sched: directed scenarios plus a randomized run
// scored against an FTQ/resolution-order model.
module tb_ftq_update_sched;
   import ftq_pkg::*;

   localparam int UPD_DEPTH = 4;

   logic        clk_i = 1'b0;
   logic        rst_i, flush_i, debug_mode_i;
   logic [1:0]  res_valid_i, res_ready_o, res_taken_i, res_mispredict_i;
   logic [63:0] res_pc_i;
   logic        ftq_empty_i;
   logic [2:0]  ftq_head_count_i;
   logic        ftq_pop_o, ftq_flush_o, upd_valid_o, upd_ready_i;
   logic [31:0] upd_pc_o;
   logic        upd_taken_o, upd_mispredict_o, busy_o;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk_i = ~clk_i;

   ftq_update_sched #(.NR_RES_PORTS(2), .UPD_DEPTH(UPD_DEPTH)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .debug_mode_i(debug_mode_i),
      .res_valid_i(res_valid_i), .res_ready_o(res_ready_o), .res_pc_i(res_pc_i),
      .res_taken_i(res_taken_i), .res_mispredict_i(res_mispredict_i),
      .ftq_empty_i(ftq_empty_i), .ftq_head_count_i(ftq_head_count_i),
      .ftq_pop_o(ftq_pop_o), .ftq_flush_o(ftq_flush_o), .upd_valid_o(upd_valid_o),
      .upd_ready_i(upd_ready_i), .upd_pc_o(upd_pc_o), .upd_taken_o(upd_taken_o),
      .upd_mispredict_o(upd_mispredict_o), .busy_o(busy_o)
   );

   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic drive_idle();
      flush_i = 1'b0; debug_mode_i = 1'b0; res_valid_i = 2'b00; res_taken_i = 2'b00;
      res_mispredict_i = 2'b00; res_pc_i = 64'd0; ftq_empty_i = 1'b1;
      ftq_head_count_i = 3'd0; upd_ready_i = 1'b0;
   endtask

   task automatic drive_res(input int p, input logic [31:0] pc, input logic tk, input logic mp);
      res_valid_i[p] = 1'b1; res_pc_i[p*32 +: 32] = pc;
      res_taken_i[p] = tk;   res_mispredict_i[p] = mp;
   endtask

   task automatic test_reset();
      drive_idle(); rst_i = 1'b1;
      cyc(); cyc();
      rst_i = 1'b0; settle();
      n_tests++; if (res_ready_o !== 2'b11) begin n_fail++; $display("FAIL reset_ready: got %b expected 11", res_ready_o); end
      n_tests++; if ({upd_valid_o, ftq_pop_o, ftq_flush_o, busy_o} !== 4'b0000) begin n_fail++; $display("FAIL reset_ctrl: got %b expected 0000", {upd_valid_o, ftq_pop_o, ftq_flush_o, busy_o}); end
      n_tests++; if ({upd_pc_o, upd_taken_o, upd_mispredict_o} !== 34'd0) begin n_fail++; $display("FAIL reset_upd: got %h expected 0", {upd_pc_o, upd_taken_o, upd_mispredict_o}); end
   endtask

   task automatic test_basic();
      drive_idle(); ftq_empty_i = 1'b0; ftq_head_count_i = 3'd2; upd_ready_i = 1'b1;
      drive_res(0, 32'h8000_0010, 1'b0, 1'b0);
      cyc();
      drive_res(0, 32'h8000_0014, 1'b0, 1'b0); settle();
      n_tests++; if ({upd_valid_o, ftq_pop_o} !== 2'b10) begin n_fail++; $display("FAIL basic_hs1: got valid,pop=%b expected 10", {upd_valid_o, ftq_pop_o}); end
      n_tests++; if (upd_pc_o !== 32'h8000_0010) begin n_fail++; $display("FAIL basic_pc1: got %h expected 80000010", upd_pc_o); end
      cyc();
      res_valid_i = 2'b00; ftq_empty_i = 1'b1; settle();
      n_tests++; if ({upd_valid_o, ftq_pop_o} !== 2'b11) begin n_fail++; $display("FAIL basic_hs2: got valid,pop=%b expected 11", {upd_valid_o, ftq_pop_o}); end
      n_tests++; if (upd_pc_o !== 32'h8000_0014) begin n_fail++; $display("FAIL basic_pc2: got %h expected 80000014", upd_pc_o); end
      cyc();
      n_tests++; if ({upd_valid_o, ftq_pop_o, busy_o} !== 3'b000) begin n_fail++; $display("FAIL basic_idle: got %b expected 000", {upd_valid_o, ftq_pop_o, busy_o}); end
   endtask

   task automatic test_dual_push();
      drive_idle(); ftq_empty_i = 1'b0; ftq_head_count_i = 3'd2;
      drive_res(0, 32'h100, 1'b1, 1'b0); drive_res(1, 32'h104, 1'b0, 1'b0);
      cyc();
      res_valid_i = 2'b00; settle();
      n_tests++; if (res_ready_o !== 2'b11) begin n_fail++; $display("FAIL dual_ready_half: got %b expected 11", res_ready_o); end
      n_tests++; if ({upd_valid_o, upd_pc_o, upd_taken_o} !== {1'b1, 32'h100, 1'b1}) begin n_fail++; $display("FAIL dual_first: got pc %h taken %b expected 100 1", upd_pc_o, upd_taken_o); end
      drive_res(0, 32'h108, 1'b0, 1'b0);
      cyc();
      res_valid_i = 2'b00; settle();
      n_tests++; if (res_ready_o !== 2'b01) begin n_fail++; $display("FAIL dual_ready_3q: got %b expected 01", res_ready_o); end
      upd_ready_i = 1'b1; settle();
      n_tests++; if (ftq_pop_o !== 1'b0) begin n_fail++; $display("FAIL dual_pop_early: got %b expected 0", ftq_pop_o); end
      cyc();
      ftq_empty_i = 1'b1; settle();
      n_tests++; if ({upd_pc_o, ftq_pop_o} !== {32'h104, 1'b1}) begin n_fail++; $display("FAIL dual_second: got pc %h pop %b expected 104 1", upd_pc_o, ftq_pop_o); end
      cyc();
      n_tests++; if ({upd_valid_o, busy_o} !== 2'b01) begin n_fail++; $display("FAIL dual_leftover: got valid,busy=%b expected 01", {upd_valid_o, busy_o}); end
      ftq_empty_i = 1'b0; ftq_head_count_i = 3'd1;
      cyc();
      ftq_empty_i = 1'b1; settle();
      n_tests++; if ({upd_valid_o, upd_pc_o, ftq_pop_o} !== {1'b1, 32'h108, 1'b1}) begin n_fail++; $display("FAIL dual_third: got pc %h pop %b expected 108 1", upd_pc_o, ftq_pop_o); end
      cyc();
      n_tests++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL dual_done: got busy %b expected 0", busy_o); end
   endtask

   task automatic test_mispredict();
      drive_idle(); ftq_empty_i = 1'b0; ftq_head_count_i = 3'd2; upd_ready_i = 1'b1;
      drive_res(0, 32'h200, 1'b1, 1'b1);
      cyc();
      drive_res(0, 32'h204, 1'b0, 1'b0); ftq_empty_i = 1'b1; settle();
      n_tests++; if ({upd_valid_o, upd_pc_o, upd_mispredict_o} !== {1'b1, 32'h200, 1'b1}) begin n_fail++; $display("FAIL mis_update: got v %b pc %h mis %b expected 1 200 1", upd_valid_o, upd_pc_o, upd_mispredict_o); end
      n_tests++; if ({ftq_pop_o, ftq_flush_o} !== 2'b00) begin n_fail++; $display("FAIL mis_nopop: got pop,flush=%b expected 00", {ftq_pop_o, ftq_flush_o}); end
      cyc();
      res_valid_i = 2'b00; settle();
      n_tests++; if ({ftq_flush_o, upd_valid_o, ftq_pop_o, res_ready_o} !== 5'b10000) begin n_fail++; $display("FAIL mis_flush_state: got flush,valid,pop,ready=%b expected 10000", {ftq_flush_o, upd_valid_o, ftq_pop_o, res_ready_o}); end
      cyc();
      n_tests++; if ({ftq_flush_o, busy_o, res_ready_o} !== 4'b0011) begin n_fail++; $display("FAIL mis_after: got flush,busy,ready=%b expected 0011", {ftq_flush_o, busy_o, res_ready_o}); end
   endtask

   task automatic test_backpressure();
      drive_idle(); ftq_empty_i = 1'b0; ftq_head_count_i = 3'd4;
      for (int k = 0; k < 5; k++) begin
         drive_res(0, 32'h300 + 32'(4 * k), 1'b0, 1'b0); settle();
         n_tests++; if (res_ready_o[0] !== (k < 4)) begin n_fail++; $display("FAIL bp_ready%0d: got %b expected %b", k, res_ready_o[0], (k < 4)); end
         if (k > 0) begin
            n_tests++; if ({upd_valid_o, upd_pc_o} !== {1'b1, 32'h300}) begin n_fail++; $display("FAIL bp_stall%0d: got v %b pc %h expected 1 300", k, upd_valid_o, upd_pc_o); end
         end
         cyc();
      end
      res_valid_i = 2'b00; upd_ready_i = 1'b1;
      for (int k = 0; k < 4; k++) begin
         if (k == 3) ftq_empty_i = 1'b1;
         settle();
         n_tests++; if ({upd_valid_o, upd_pc_o, ftq_pop_o} !== {1'b1, 32'h300 + 32'(4 * k), (k == 3)}) begin n_fail++; $display("FAIL bp_drain%0d: got v %b pc %h pop %b", k, upd_valid_o, upd_pc_o, ftq_pop_o); end
         cyc();
      end
      n_tests++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL bp_done: got busy %b expected 0", busy_o); end
   endtask

   task automatic test_debug();
      drive_idle(); ftq_empty_i = 1'b0; ftq_head_count_i = 3'd2; upd_ready_i = 1'b1; debug_mode_i = 1'b1;
      drive_res(0, 32'h400, 1'b1, 1'b0);
      cyc();
      drive_res(0, 32'h404, 1'b0, 1'b0);
      cyc();
      res_valid_i = 2'b00;
      for (int k = 0; k < 3; k++) begin
         settle();
         n_tests++; if ({upd_valid_o, ftq_pop_o} !== 2'b00) begin n_fail++; $display("FAIL dbg_hold%0d: got valid,pop=%b expected 00", k, {upd_valid_o, ftq_pop_o}); end
         cyc();
      end
      debug_mode_i = 1'b0; settle();
      n_tests++; if ({upd_valid_o, upd_pc_o, ftq_pop_o} !== {1'b1, 32'h400, 1'b0}) begin n_fail++; $display("FAIL dbg_first: got v %b pc %h pop %b expected 1 400 0", upd_valid_o, upd_pc_o, ftq_pop_o); end
      cyc();
      ftq_empty_i = 1'b1; settle();
      n_tests++; if ({upd_valid_o, upd_pc_o, ftq_pop_o} !== {1'b1, 32'h404, 1'b1}) begin n_fail++; $display("FAIL dbg_second: got v %b pc %h pop %b expected 1 404 1", upd_valid_o, upd_pc_o, ftq_pop_o); end
      cyc();
      n_tests++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL dbg_done: got busy %b expected 0", busy_o); end
   endtask

   task automatic test_flush();
      drive_idle(); ftq_empty_i = 1'b0; ftq_head_count_i = 3'd2;
      drive_res(0, 32'h500, 1'b0, 1'b0); drive_res(1, 32'h504, 1'b0, 1'b0);
      cyc();
      drive_res(0, 32'h508, 1'b0, 1'b0); drive_res(1, 32'h50c, 1'b0, 1'b0);
      cyc();
      res_valid_i = 2'b00; upd_ready_i = 1'b1; settle();
      n_tests++; if ({upd_pc_o, ftq_pop_o} !== {32'h500, 1'b0}) begin n_fail++; $display("FAIL fl_first: got pc %h pop %b expected 500 0", upd_pc_o, ftq_pop_o); end
      cyc();
      flush_i = 1'b1; ftq_empty_i = 1'b1; settle();
      n_tests++; if ({upd_valid_o, upd_pc_o, ftq_pop_o, res_ready_o} !== {1'b1, 32'h504, 1'b0, 2'b00}) begin n_fail++; $display("FAIL fl_during: got v %b pc %h pop %b rdy %b expected 1 504 0 00", upd_valid_o, upd_pc_o, ftq_pop_o, res_ready_o); end
      cyc();
      flush_i = 1'b0; upd_ready_i = 1'b0; settle();
      n_tests++; if ({busy_o, upd_valid_o, ftq_pop_o, ftq_flush_o, res_ready_o} !== 6'b000011) begin n_fail++; $display("FAIL fl_after: got busy,v,pop,flush,rdy=%b expected 000011", {busy_o, upd_valid_o, ftq_pop_o, ftq_flush_o, res_ready_o}); end
   endtask

   task automatic test_reset_active();
      drive_idle(); ftq_empty_i = 1'b0; ftq_head_count_i = 3'd2;
      drive_res(0, 32'hdead_beef, 1'b1, 1'b1);
      cyc();
      res_valid_i = 2'b00; settle();
      n_tests++; if ({busy_o, upd_valid_o} !== 2'b11) begin n_fail++; $display("FAIL rst_pre: got busy,valid=%b expected 11", {busy_o, upd_valid_o}); end
      rst_i = 1'b1;
      cyc();
      rst_i = 1'b0; ftq_empty_i = 1'b1; settle();
      n_tests++; if ({upd_valid_o, ftq_pop_o, ftq_flush_o, busy_o, res_ready_o} !== 6'b000011) begin n_fail++; $display("FAIL rst_mid_ctrl: got %b expected 000011", {upd_valid_o, ftq_pop_o, ftq_flush_o, busy_o, res_ready_o}); end
      n_tests++; if ({upd_pc_o, upd_taken_o, upd_mispredict_o} !== 34'd0) begin n_fail++; $display("FAIL rst_mid_upd: got %h expected 0", {upd_pc_o, upd_taken_o, upd_mispredict_o}); end
   endtask

   // Model: resolutions retire in push order; entry k pops after exactly cnts[k] updates.
   task automatic test_random();
      int          cnts[$];
      logic [32:0] sb[$];
      int          head, hs_in_entry, total, pushed, cycles;
      drive_idle();
      total = 0;
      for (int i = 0; i < 30; i++) begin
         cnts.push_back(($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 4)));
         total += cnts[i];
      end
      head = 0; hs_in_entry = 0; pushed = 0; cycles = 0;
      while ((head < cnts.size() || sb.size() != 0) && cycles < 4000) begin
         logic [1:0]  v, exp_rdy;
         logic [32:0] d0, d1;
         logic        hs, exp_pop;
         ftq_empty_i      = (head >= cnts.size());
         ftq_head_count_i = (head < cnts.size()) ? 3'(cnts[head]) : 3'd0;
         upd_ready_i      = ($urandom_range(0, 3) != 0);
         debug_mode_i     = ($urandom_range(0, 15) == 0);
         v = 2'($urandom_range(0, 3));
         if (pushed >= total) v = 2'b00;
         else if (pushed + 1 == total) v[1] = 1'b0;
         d0 = {1'($urandom), 32'($urandom)};
         d1 = {1'($urandom), 32'($urandom)};
         res_valid_i = v; res_pc_i = {d1[31:0], d0[31:0]};
         res_taken_i = {d1[32], d0[32]}; res_mispredict_i = 2'b00;
         settle();
         exp_rdy = {(sb.size() <= UPD_DEPTH - 2), (sb.size() <= UPD_DEPTH - 1)};
         n_tests++; if (res_ready_o !== exp_rdy) begin n_fail++; $display("FAIL rnd_ready: got %b expected %b at cycle %0d", res_ready_o, exp_rdy, cycles); end
         if (upd_valid_o && (debug_mode_i || sb.size() == 0)) begin
            n_tests++; n_fail++; $display("FAIL rnd_spurious_valid: got 1 expected 0 at cycle %0d", cycles);
         end
         hs = upd_valid_o && upd_ready_i;
         if (hs && sb.size() != 0) begin
            n_tests++; if ({upd_taken_o, upd_pc_o} !== sb[0]) begin n_fail++; $display("FAIL rnd_order: got %h expected %h at cycle %0d", {upd_taken_o, upd_pc_o}, sb[0], cycles); end
            hs_in_entry++;
            exp_pop = (head < cnts.size()) && (hs_in_entry == cnts[head]);
            n_tests++; if (ftq_pop_o !== exp_pop) begin n_fail++; $display("FAIL rnd_pop: got %b expected %b at cycle %0d", ftq_pop_o, exp_pop, cycles); end
            void'(sb.pop_front());
         end else if (ftq_pop_o) begin
            n_tests++;
            if (!(head < cnts.size() && cnts[head] == 0 && hs_in_entry == 0)) begin n_fail++; $display("FAIL rnd_pop_nohs: got 1 expected 0 at cycle %0d", cycles); end
         end
         if (ftq_pop_o) begin head++; hs_in_entry = 0; end
         if (v[0] && res_ready_o[0]) begin sb.push_back(d0); pushed++; end
         if (v[1] && res_ready_o[1]) begin sb.push_back(d1); pushed++; end
         cyc();
         cycles++;
      end
      n_tests++; if (cycles >= 4000) begin n_fail++; $display("FAIL rnd_timeout: got %0d entries retired expected %0d", head, cnts.size()); end
      drive_idle(); settle();
      n_tests++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL rnd_done: got busy %b expected 0", busy_o); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_dual_push();
      test_mispredict();
      test_backpressure();
      test_debug();
      test_flush();
      test_reset_active();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ftq_update_sched.md
Name: ftq_update_sched

Overview:
- Sequences resolved-branch updates from the branch units into the branch predictor update port.
- Pops FTQ entries once every prediction in an entry has been resolved.
- Issues an FTQ flush after a mispredict update.
- Sits between the execute-stage branch units (NR_RES_PORTS resolution ports, port 0 always older) and the predictor/FTQ pair. It owns the per-entry remaining-prediction counter and the update ordering.

Parameters:
- CVA6Cfg, config_pkg::cva6_cfg_empty: core configuration; supplies VLEN and LOG2_INSTR_PER_FETCH.
- NR_RES_PORTS, 2: number of branch resolution ports; legal values are 1 and 2.
- UPD_DEPTH, 4: depth of the internal resolution FIFO; power of 2 and ≥ NR_RES_PORTS.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- flush_i  in  1  external pipeline flush.
- debug_mode_i  in  1  when 1, no updates are issued and the FIFO holds.
- res_valid_i  in  NR_RES_PORTS  resolution valid per port.
- res_ready_o  out  NR_RES_PORTS  resolution accept per port.
- res_pc_i  in  NR_RES_PORTS*VLEN  branch PC per port.
- res_taken_i  in  NR_RES_PORTS  resolved direction.
- res_mispredict_i  in  NR_RES_PORTS  resolution was a mispredict.
- ftq_empty_i  in  1  FTQ empty.
- ftq_head_count_i  in  LOG2_INSTR_PER_FETCH+1  bp_count of the FTQ head entry.
- ftq_pop_o  out  1  pop the FTQ head (single-cycle pulse).
- ftq_flush_o  out  1  flush the FTQ (single-cycle pulse).
- upd_valid_o  out  1  predictor update valid.
- upd_ready_i  in  1  predictor accepts the update.
- upd_pc_o  out  VLEN  update PC.
- upd_taken_o  out  1  update direction.
- upd_mispredict_o  out  1  update is a mispredict.
- busy_o  out  1  FIFO non-empty or state ≠ IDLE.

Behaviour:
- Reset (rst_i=1 at a clock edge):
  - State IDLE, rem counter 0, FIFO empty.
  - All outputs 0 except res_ready_o = all 1.
  - Reset mid-operation discards all buffered resolutions.
- Resolution FIFO:
  - Shared, in-order, UPD_DEPTH entries {pc, taken, mispredict}.
  - Up to NR_RES_PORTS pushes per cycle; port 0 is written before port 1 (older first).
  - Ready rules: res_ready_o[0] = free≥1; res_ready_o[1] = free≥2.
  - res_ready_o = 0 in FLUSH and while flush_i=1.
  - Ready has no combinational dependency on res_valid_i.
  - A push and a pop in the same cycle are allowed. Free count uses the registered state, so a pop in the same cycle does not raise ready.
- rem counter: width LOG2_INSTR_PER_FETCH+1 bits; never decremented below 0.
- FSM states: IDLE, ACTIVE, FLUSH.
- IDLE:
  - If ftq_empty_i=0, load rem = ftq_head_count_i and go to ACTIVE next cycle.
  - Special case ftq_head_count_i=0: pulse ftq_pop_o, stay IDLE, rem unchanged.
- ACTIVE:
  - upd_* = FIFO head; upd_valid_o = FIFO non-empty & ~debug_mode_i.
  - Outputs are registered FIFO contents, so latency from push to upd_valid_o is 1 cycle.
  - On upd_valid_o & upd_ready_i: pop the FIFO and decrement rem.
    - If head.mispredict=1: go to FLUSH. No ftq_pop_o this cycle; the FLUSH state handles the FTQ.
    - Else if rem becomes 0: pulse ftq_pop_o the same cycle and go to IDLE.
    - Else: stay in ACTIVE.
  - Back-to-back updates: one per cycle while upd_ready_i=1.
- FLUSH (exactly 1 cycle):
  - ftq_flush_o=1, FIFO cleared, rem=0, upd_valid_o=0; then IDLE.
- flush_i (any state):
  - Next cycle: FIFO cleared, rem=0, state IDLE, no ftq_pop_o.
  - ftq_flush_o is not asserted; the external source flushes the FTQ.
  - flush_i takes priority over a same-cycle update handshake: the handshake completes on the predictor side, but no pop or FLUSH follows.
- debug_mode_i=1: upd_valid_o=0 and the FIFO holds. Pushes continue until the FIFO is full; no updates are lost.
- FIFO wrap-around uses pointer roll-over at UPD_DEPTH. Full stalls producers only; ordering is preserved.

Decomposition:
- Shared package ftq_pkg:
  - res_entry_t {pc, taken, mispredict}.
  - sched_state_e {IDLE, ACTIVE, FLUSH}.
  - bp_count width constant.
- One sub-module: ftq_res_fifo, a multi-push (≤2) single-pop FIFO with free count, synchronous clear and synchronous active-high reset.
- The FSM and rem counter live in the top module.

Test Plan:
- Basic entry: reset; FTQ head count=2, not empty; push not-taken resolutions PC 0x80000010 then 0x80000014 on port 0, upd_ready_i=1.
  - Expect upd_valid_o on 2 consecutive cycles with those PCs.
  - Expect ftq_pop_o pulse on the 2nd handshake, then state IDLE.
- Dual push: push on both ports in one cycle (p0 PC 0x100, p1 PC 0x104), head count=2.
  - Expect update order 0x100 then 0x104.
  - With FIFO at 3/4 full, expect res_ready_o=2'b01.
- Mispredict: head count=2; first resolution has mispredict=1.
  - Expect 1 update, no ftq_pop_o, then ftq_flush_o=1 for exactly one cycle.
  - Expect FIFO empty and res_ready_o=0 during FLUSH; then IDLE.
- Backpressure and full FIFO: hold upd_ready_i=0 while pushing 5 resolutions on port 0.
  - Expect res_ready_o[0]=0 after 4 accepted; upd_pc_o stable while stalled.
  - Release: expect 4 updates in order, one per cycle.
- Debug mode: debug_mode_i=1 with 2 entries buffered.
  - Expect upd_valid_o=0 and no pop.
  - Deassert debug_mode_i: expect both updates and a pop when the count reaches 0.
- Flush and reset: flush_i=1 mid-entry with rem=1 and 3 buffered.
  - Next cycle: FIFO empty, IDLE, no ftq_pop_o or ftq_flush_o.
  - rst_i=1 during ACTIVE: next cycle all outputs 0, res_ready_o all 1.
